// File: rtl/pipe_xfer_stage_if.sv
// Valid/ready transfer bundle around one pipe_xfer_stage: upstream (in_*) and downstream (out_*) sides.
// slave = the stage's view, master = the surrounding pipeline's view.
interface pipe_xfer_stage_if #(
  parameter int DATA_W = 96,
  parameter int INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_inst, in_data, out_ready,
    output in_ready, out_valid, out_inst, out_data
  );

  modport master (
    output in_valid, in_inst, in_data, out_ready,
    input  in_ready, out_valid, out_inst, out_data
  );
endinterface

// File: rtl/pipe_xfer_stage.sv
// Pipeline transfer register with a two-entry skid buffer, flush-to-bubble and optional stall/bubble
// counters (enabled by PIPE_XFER_STAGE_PERF_EN). All state updates on the falling edge of clk.
module pipe_xfer_stage #(
  parameter int                DATA_W   = 96,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_xfer_stage_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t            r_state_p1, w_state_nxt;
  logic              r_in_ready_p1;
  logic [INST_W-1:0] r_m_inst_p1, r_s_inst_p1;
  logic [DATA_W-1:0] r_m_data_p1, r_s_data_p1;
  logic              w_out_valid, w_accept, w_drain;
  logic              w_ld_main, w_ld_skid, w_mv_skid;

  assign w_out_valid = (r_state_p1 != ST_EMPTY);
  assign w_accept    = bus.in_valid & r_in_ready_p1;
  assign w_drain     = w_out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt = r_state_p1;
    w_ld_main   = 1'b0;
    w_ld_skid   = 1'b0;
    w_mv_skid   = 1'b0;
    case (r_state_p1)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_ld_main   = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_ld_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_drain) begin
          w_state_nxt = ST_ONE;
          w_mv_skid   = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Stage p1 control: in_ready is held low during reset and follows "skid empty" otherwise
  always_ff @(negedge clk) begin
    if (reset) begin
      r_state_p1    <= ST_EMPTY;
      r_in_ready_p1 <= 1'b0;
    end else if (flush) begin
      r_state_p1    <= ST_EMPTY;
      r_in_ready_p1 <= 1'b1;
    end else begin
      r_state_p1    <= w_state_nxt;
      r_in_ready_p1 <= (w_state_nxt != ST_FULL);
    end
  end

  // Stage p1 payload: contents of invalid entries are don't-care, so no reset
  always_ff @(negedge clk) begin
    if (w_ld_main) begin
      r_m_inst_p1 <= bus.in_inst;
      r_m_data_p1 <= bus.in_data;
    end else if (w_mv_skid) begin
      r_m_inst_p1 <= r_s_inst_p1;
      r_m_data_p1 <= r_s_data_p1;
    end
    if (w_ld_skid) begin
      r_s_inst_p1 <= bus.in_inst;
      r_s_data_p1 <= bus.in_data;
    end
  end

  assign bus.in_ready  = r_in_ready_p1;
  assign bus.out_valid = w_out_valid;
  assign bus.out_inst  = w_out_valid ? r_m_inst_p1 : NOP_INST;
  assign bus.out_data  = w_out_valid ? r_m_data_p1 : '0;

`ifdef PIPE_XFER_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Counters observe the handshake seen before each edge; only reset clears them
  always_ff @(negedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_out_valid && !bus.out_ready) r_stall_cnt  <= sat_inc(r_stall_cnt);
      if (!w_out_valid && bus.out_ready) r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_xfer_stage.sv
// Directed bench for pipe_xfer_stage: reset, streaming, back-pressure, flush and counter saturation.
module tb_pipe_xfer_stage;
  localparam int                DATA_W = 96;
  localparam int                INST_W = 32;
  localparam int                CNT_W  = 4;
  localparam logic [INST_W-1:0] NOP    = 32'h0000_0013;
`ifdef PIPE_XFER_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  pipe_xfer_stage_if #(.DATA_W(DATA_W), .INST_W(INST_W)) bus ();

  pipe_xfer_stage #(
    .DATA_W(DATA_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One falling (active) edge; outputs are then sampled at the following rising edge
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask

  function automatic logic [DATA_W-1:0] pay(input logic [INST_W-1:0] inst);
    return {inst ^ 32'hA5A5_0000, ~inst, inst};
  endfunction

  function automatic logic [CNT_W-1:0] cexp(input int v);
    return PERF ? v[CNT_W-1:0] : '0;
  endfunction

  task automatic offer(input logic v, input logic [INST_W-1:0] inst);
    bus.in_valid = v;
    bus.in_inst  = inst;
    bus.in_data  = pay(inst);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [INST_W-1:0] inst);
    chk({tag, ".valid"}, bus.out_valid, v);
    chk({tag, ".inst"},  bus.out_inst,  v ? inst : NOP);
    chk({tag, ".data"},  bus.out_data,  v ? pay(inst) : '0);
  endtask

  task automatic expect_cnt(input string tag, input int st, input int bu);
    chk({tag, ".stall"},  stall_cnt,  cexp(st));
    chk({tag, ".bubble"}, bubble_cnt, cexp(bu));
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    offer(1'b0, 32'h0);
    cyc();
    cyc();
    expect_out("rst", 1'b0, NOP);
    chk("rst.in_ready", bus.in_ready, 1'b0);
    expect_cnt("rst", 0, 0);

    reset = 1'b0;
    cyc();
    chk("rel.in_ready", bus.in_ready, 1'b1);
    expect_out("rel", 1'b0, NOP);
    expect_cnt("rel", 0, 0);

    // Streaming at full rate: first edge counts one bubble
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 32'h100 + i);
      cyc();
      expect_out($sformatf("strm%0d", i), 1'b1, 32'h100 + i);
      chk($sformatf("strm%0d.in_ready", i), bus.in_ready, 1'b1);
    end
    offer(1'b0, 32'h0);
    cyc();
    expect_out("strm_end", 1'b0, NOP);
    expect_cnt("strm_end", 0, 1);

    // Back-pressure into FULL, then drain A then B; C offered while leaving FULL is refused
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h200);
    cyc();
    expect_out("bp_a", 1'b1, 32'h200);
    chk("bp_a.in_ready", bus.in_ready, 1'b1);
    offer(1'b1, 32'h201);
    cyc();
    expect_out("bp_full", 1'b1, 32'h200);
    chk("bp_full.in_ready", bus.in_ready, 1'b0);
    offer(1'b1, 32'h202);
    cyc();
    expect_out("bp_hold", 1'b1, 32'h200);
    chk("bp_hold.in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    cyc();
    expect_out("bp_b", 1'b1, 32'h201);
    chk("bp_b.in_ready", bus.in_ready, 1'b1);
    offer(1'b0, 32'h0);
    cyc();
    expect_out("bp_end", 1'b0, NOP);
    expect_cnt("bp_end", 2, 1);

    // Flush while FULL with C offered
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h300);
    cyc();
    offer(1'b1, 32'h301);
    cyc();
    chk("fl_full.in_ready", bus.in_ready, 1'b0);
    expect_out("fl_full", 1'b1, 32'h300);
    flush = 1'b1;
    offer(1'b1, 32'h302);
    cyc();
    expect_out("fl_cut", 1'b0, NOP);
    chk("fl_cut.in_ready", bus.in_ready, 1'b1);
    flush = 1'b0;
    offer(1'b0, 32'h0);
    bus.out_ready = 1'b1;
    cyc();
    expect_out("fl_after", 1'b0, NOP);

    // Flush drops an accept taken while in_ready=1
    offer(1'b1, 32'h400);
    cyc();
    expect_out("fl_d", 1'b1, 32'h400);
    flush = 1'b1;
    offer(1'b1, 32'h401);
    cyc();
    expect_out("fl_e", 1'b0, NOP);
    chk("fl_e.in_ready", bus.in_ready, 1'b1);
    flush = 1'b0;
    offer(1'b0, 32'h0);
    cyc();
    expect_out("fl_e2", 1'b0, NOP);
    expect_cnt("fl_end", 4, 4);

    // Counter saturation, flush keeps counts, reset clears
    reset = 1'b1;
    bus.out_ready = 1'b0;
    cyc();
    expect_cnt("rst2", 0, 0);
    reset = 1'b0;
    cyc();
    offer(1'b1, 32'h500);
    cyc();
    offer(1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 9) expect_cnt("sat10", 10, 0);
    end
    expect_out("sat_hold", 1'b1, 32'h500);
    expect_cnt("sat20", 15, 0);
    flush = 1'b1;
    cyc();
    expect_cnt("sat_flush", 15, 0);
    expect_out("sat_flush", 1'b0, NOP);
    flush = 1'b0;
    offer(1'b1, 32'h600);
    cyc();
    expect_out("pre_rst", 1'b1, 32'h600);

    // Reset together with flush mid-operation
    reset = 1'b1;
    flush = 1'b1;
    cyc();
    expect_out("rstfl", 1'b0, NOP);
    chk("rstfl.in_ready", bus.in_ready, 1'b0);
    expect_cnt("rstfl", 0, 0);
    reset = 1'b0;
    flush = 1'b0;
    offer(1'b0, 32'h0);
    cyc();
    chk("final.in_ready", bus.in_ready, 1'b1);
    expect_out("final", 1'b0, NOP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
